// File: rtl/refresh_scan.sv
// Display refresh sequencer: walks the digit index through FIRST_DIG..LAST_DIG,
// skipping masked digits. A blanking gap at the start of each slot suppresses
// ghosting, and the digit value is snapshotted at each slot advance.
module refresh_scan #(
  parameter int PRESCALE  = 100000,
  parameter int BLANK_CYC = 16,
  parameter int FIRST_DIG = 4,
  parameter int LAST_DIG  = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [31:0] digits_in,
  input  logic [7:0]  dig_mask,
  output logic [2:0]  rc_out,
  output logic [3:0]  dig_val,
  output logic        blank,
  output logic        tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int N  = LAST_DIG - FIRST_DIG + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BLANK = 2'd1;
  localparam logic [1:0] SHOW  = 2'd2;

  logic [1:0]    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic          hold, hold_n;   // in BLANK with no shown digit; wait for slot end
  logic [3:0]    val_n;
  logic          tick_n, load;
  logic [2:0]    start;
  logic [3:0]    hit;            // {found, index}
  logic          slot_end, blank_end;

  // Cyclic search through the scan range starting at 'from'; the
  // lowest offset that has its mask bit set wins.
  function automatic logic [3:0] find_dig(input logic [2:0] from, input logic [7:0] m);
    logic [3:0] r;
    int c;
    r = '0;
    for (int o = N - 1; o >= 0; o--) begin
      c = FIRST_DIG + ((int'(from) - FIRST_DIG + o) % N);
      if (m[c[2:0]]) r = {1'b1, c[2:0]};
    end
    return r;
  endfunction

  assign slot_end  = (cnt == CW'(PRESCALE - 1));
  assign blank_end = (BLANK_CYC != 0) && (cnt == CW'(BLANK_CYC - 1));

  // Search starts at FIRST_DIG when leaving IDLE, else just past the current
  // digit, so the current digit is the last candidate.
  assign start = (state == IDLE || idx == 3'(LAST_DIG)) ? 3'(FIRST_DIG) : idx + 3'd1;
  assign hit   = find_dig(start, dig_mask);

  // Next-state, prescaler and snapshot logic.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    val_n   = dig_val;
    hold_n  = hold;
    tick_n  = 1'b0;
    load    = 1'b0;
    cnt_n   = slot_end ? '0 : cnt + 1'b1;
    if (!en) begin
      state_n = IDLE;
      cnt_n   = '0;
      idx_n   = 3'(FIRST_DIG);
      hold_n  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt_n = '0;
          load  = hit[3];
        end
        BLANK: begin
          if (hold) load = slot_end && hit[3];
          else if (blank_end) state_n = SHOW;
        end
        SHOW: begin
          if (slot_end) begin
            load = hit[3];
            if (!hit[3]) begin
              state_n = BLANK;
              hold_n  = 1'b1;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
    if (load) begin
      idx_n   = hit[2:0];
      val_n   = digits_in[{hit[2:0], 2'b00} +: 4];
      tick_n  = 1'b1;
      cnt_n   = '0;
      hold_n  = 1'b0;
      state_n = (BLANK_CYC == 0) ? SHOW : BLANK;
    end
  end

  // State registers and registered outputs derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= 3'(FIRST_DIG);
      hold    <= 1'b0;
      rc_out  <= 3'd0;
      dig_val <= 4'd0;
      blank   <= 1'b1;
      tick    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      hold    <= hold_n;
      rc_out  <= (state_n == SHOW) ? idx_n : 3'd0;
      dig_val <= val_n;
      blank   <= (state_n != SHOW);
      tick    <= tick_n;
    end
  end

endmodule
